// File: rtl/hls_fp17_mul_core_chn_o_rsci_out_ctrl.sv
// Output-channel transmitter for the fp17 multiplier core.
// Core results are pushed into a small skid FIFO and presented on the
// chn_o valid/ready interface. The core sees backpressure (bcwt) when the
// FIFO is full.
//
// Handshake: a transfer on chn_o happens in a cycle where chn_o_pvld and
// chn_o_prdy are both 1 at the rising edge. While pvld=1 and no transfer
// happens, pvld and pd are held stable. On the core side a push is taken
// only when iswt0=1, core_wten=0 and rdy=1. rdy and bcwt are derived only
// from registered occupancy, so a pop in the same cycle never opens a slot
// for a push when the FIFO is full.
module hls_fp17_mul_core_chn_o_rsci_out_ctrl #(
   parameter int DATA_WIDTH = 17,
   parameter int DEPTH      = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  nvdla_core_clk,
   input  logic                  nvdla_core_rst,
   input  logic                  core_wten,
   input  logic                  chn_o_rsci_iswt0,
   input  logic [DATA_WIDTH-1:0] chn_o_rsci_d,
   output logic                  chn_o_rsci_rdy,
   output logic                  chn_o_rsci_bcwt,
   output logic                  chn_o_pvld,
   input  logic                  chn_o_prdy,
   output logic [DATA_WIDTH-1:0] chn_o_pd,
   input  logic                  stall_clr,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CNT_WIDTH-1:0]  stall_q, stall_d;
   logic                  push;
   logic                  pop;

   // Status outputs come straight from registered occupancy.
   always_comb begin
      chn_o_rsci_rdy  = (count_q != FULL_CNT);
      chn_o_rsci_bcwt = (count_q == FULL_CNT);
      chn_o_pvld      = (count_q != '0);
      chn_o_pd        = mem_q[rd_ptr_q];
      stall_cnt       = stall_q;
      push            = chn_o_rsci_iswt0 & ~core_wten & chn_o_rsci_rdy;
      pop             = chn_o_pvld & chn_o_prdy;
   end

   // Next-state for pointers, occupancy and the saturating stall counter.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      stall_d  = stall_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (stall_clr) begin
         stall_d = '0;
      end else if (chn_o_pvld && !chn_o_prdy && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // State registers; reset discards buffered data and clears storage.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         stall_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         stall_q  <= stall_d;
         if (push) begin
            mem_q[wr_ptr_q] <= chn_o_rsci_d;
         end
      end
   end

endmodule

// File: tb/tb_hls_fp17_mul_core_chn_o_rsci_out_ctrl.sv
// Bench for the chn_o output controller: directed scenarios plus a
// per-cycle occupancy/scoreboard model of the FIFO and stall counter.
module tb_hls_fp17_mul_core_chn_o_rsci_out_ctrl;

   localparam int W = 17;

   logic          clk;
   logic          rst;
   logic          wten;
   logic          iswt0;
   logic [W-1:0]  d;
   logic          prdy;
   logic          clr;
   logic          rdy, bcwt, pvld;
   logic [W-1:0]  pd;
   logic [15:0]   stall;
   // narrow-counter instance sharing the same stimulus, for saturation
   logic          s_rdy, s_bcwt, s_pvld;
   logic [W-1:0]  s_pd;
   logic [3:0]    s_stall;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [W-1:0]  exp_q[$];
   int            m_cnt = 0;
   logic [15:0]   m_stall = '0;
   logic          mon_en = 1'b0;

   hls_fp17_mul_core_chn_o_rsci_out_ctrl dut (
      .nvdla_core_clk   (clk),
      .nvdla_core_rst   (rst),
      .core_wten        (wten),
      .chn_o_rsci_iswt0 (iswt0),
      .chn_o_rsci_d     (d),
      .chn_o_rsci_rdy   (rdy),
      .chn_o_rsci_bcwt  (bcwt),
      .chn_o_pvld       (pvld),
      .chn_o_prdy       (prdy),
      .chn_o_pd         (pd),
      .stall_clr        (clr),
      .stall_cnt        (stall)
   );

   hls_fp17_mul_core_chn_o_rsci_out_ctrl #(.CNT_WIDTH(4)) u_sat (
      .nvdla_core_clk   (clk),
      .nvdla_core_rst   (rst),
      .core_wten        (wten),
      .chn_o_rsci_iswt0 (iswt0),
      .chn_o_rsci_d     (d),
      .chn_o_rsci_rdy   (s_rdy),
      .chn_o_rsci_bcwt  (s_bcwt),
      .chn_o_pvld       (s_pvld),
      .chn_o_prdy       (prdy),
      .chn_o_pd         (s_pd),
      .stall_clr        (clr),
      .stall_cnt        (s_stall)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [W-1:0] v);
      iswt0 = 1'b1;
      d     = v;
      tick();
      iswt0 = 1'b0;
   endtask

   // Reference model, evaluated mid-cycle against the inputs for the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         logic m_push, m_pop;
         check_eq("m_pvld", pvld, (m_cnt != 0));
         check_eq("m_rdy",  rdy,  (m_cnt != 2));
         check_eq("m_bcwt", bcwt, (m_cnt == 2));
         check_eq("m_stall", stall, m_stall);
         if (m_cnt != 0 && exp_q.size() != 0) begin
            check_eq("m_pd", pd, exp_q[0]);
         end
         if (rst) begin
            m_cnt = 0;
            exp_q.delete();
            m_stall = '0;
         end else begin
            m_pop  = (m_cnt != 0) && prdy;
            m_push = iswt0 && !wten && (m_cnt != 2);
            if (m_pop && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
            end
            if (m_push) begin
               exp_q.push_back(d);
            end
            m_cnt = m_cnt + int'(m_push) - int'(m_pop);
            if (clr) begin
               m_stall = '0;
            end else if (m_cnt_pre_pvld(m_pop, m_push) && !prdy && m_stall != 16'hFFFF) begin
               m_stall = m_stall + 16'd1;
            end
         end
      end
   end

   // recovers the occupancy before this edge's update (pvld seen at the edge)
   function automatic bit m_cnt_pre_pvld(input logic pp, input logic pu);
      return (m_cnt - int'(pu) + int'(pp)) != 0;
   endfunction

   initial begin
      rst = 1'b1; wten = 1'b0; iswt0 = 1'b0; d = '0; prdy = 1'b0; clr = 1'b0;
      tick();
      tick();
      mon_en = 1'b1;
      check_eq("rst_pvld", pvld, 0);
      check_eq("rst_rdy", rdy, 1);
      check_eq("rst_bcwt", bcwt, 0);
      check_eq("rst_pd", pd, 0);
      check_eq("rst_stall", stall, 0);
      rst = 1'b0;
      tick();

      // 1: single push, one-cycle latency, immediate pop
      prdy = 1'b1;
      push_one(17'h1ABCD);
      check_eq("t1_pvld", pvld, 1);
      check_eq("t1_pd", pd, 17'h1ABCD);
      tick();
      check_eq("t1_pvld_after", pvld, 0);
      check_eq("t1_stall", stall, 0);

      // 2: fill with prdy low, third push ignored, then drain
      prdy = 1'b0;
      iswt0 = 1'b1; d = 17'h00001; tick();
      d = 17'h00002; tick();
      check_eq("t2_rdy_full", rdy, 0);
      check_eq("t2_bcwt_full", bcwt, 1);
      d = 17'h00003; tick();
      iswt0 = 1'b0; prdy = 1'b1;
      check_eq("t2_stall", stall, 2);
      check_eq("t2_pd0", pd, 17'h00001);
      tick();
      check_eq("t2_pd1", pd, 17'h00002);
      tick();
      check_eq("t2_empty", pvld, 0);
      check_eq("t2_stall_hold", stall, 2);

      // 3: streaming 0..9 with prdy high, pointer wrap
      for (int i = 0; i < 10; i++) begin
         iswt0 = 1'b1;
         d = W'(i);
         tick();
         check_eq("t3_pd", pd, i);
         check_eq("t3_rdy", rdy, 1);
         check_eq("t3_pvld", pvld, 1);
      end
      iswt0 = 1'b0;
      tick();
      check_eq("t3_drained", pvld, 0);

      // 4: full, simultaneous pop and push request -> push rejected
      prdy = 1'b0;
      push_one(17'h00011);
      push_one(17'h00022);
      check_eq("t4_bcwt", bcwt, 1);
      prdy = 1'b1; iswt0 = 1'b1; d = 17'h00033;
      tick();
      iswt0 = 1'b0;
      check_eq("t4_rdy", rdy, 1);
      check_eq("t4_bcwt_low", bcwt, 0);
      check_eq("t4_pd", pd, 17'h00022);
      tick();
      check_eq("t4_no_extra", pvld, 0);

      // 5: stall counter saturation (4-bit instance) and clear priority
      clr = 1'b1; tick(); clr = 1'b0;
      prdy = 1'b0;
      push_one(17'h00044);
      for (int i = 0; i < 20; i++) tick();
      check_eq("t5_stall20", stall, 20);
      check_eq("t5_sat", s_stall, 4'hF);
      check_eq("t5_sat_pd", s_pd, 17'h00044);
      clr = 1'b1; tick(); clr = 1'b0;
      check_eq("t5_clr", stall, 0);
      check_eq("t5_clr_sat", s_stall, 0);
      tick();
      check_eq("t5_resume", stall, 1);
      check_eq("t5_resume_sat", s_stall, 1);
      prdy = 1'b1; tick();
      check_eq("t5_drained", pvld, 0);

      // 6: reset with two entries buffered; push/pop ignored during reset
      prdy = 1'b0;
      push_one(17'h000A1);
      push_one(17'h000A2);
      check_eq("t6_full", bcwt, 1);
      rst = 1'b1; iswt0 = 1'b1; d = 17'h00055; prdy = 1'b1;
      tick();
      rst = 1'b0; iswt0 = 1'b0; prdy = 1'b0;
      check_eq("t6_pvld", pvld, 0);
      check_eq("t6_pd", pd, 0);
      check_eq("t6_rdy", rdy, 1);
      check_eq("t6_bcwt", bcwt, 0);
      check_eq("t6_stall", stall, 0);
      push_one(17'h0F0F0);
      check_eq("t6_pd_new", pd, 17'h0F0F0);
      prdy = 1'b1;
      tick();
      check_eq("t6_alone", pvld, 0);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         iswt0 = 1'($urandom_range(0, 1));
         wten  = ($urandom_range(0, 3) == 0);
         prdy  = 1'($urandom_range(0, 1));
         clr   = ($urandom_range(0, 31) == 0);
         d     = W'($urandom_range(0, 17'h1FFFF));
         tick();
      end
      iswt0 = 1'b0; wten = 1'b0; clr = 1'b0; prdy = 1'b1;
      tick();
      tick();
      check_eq("final_empty", pvld, 0);
      check_eq("final_sb_empty", exp_q.size(), 0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
